// File: rtl/ps2_cmd_seq.sv
`timescale 1ns/1ps
// ps2_cmd_seq: runs complete PS/2 device transactions on top of ps2_host.
// Sends a command byte (and optional argument), waits for each 0xFA, resends
// on 0xFE up to MAX_RETRY times, collects up to three response bytes and
// applies a per-byte reply timeout. Bytes arriving while idle are forwarded
// as scan codes.
module ps2_cmd_seq #(
    parameter int CLK_FREQ       = 100,
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter int MAX_RETRY      = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_byte,
    input  logic        cmd_has_arg,
    input  logic [7:0]  cmd_arg,
    input  logic [1:0]  cmd_rsp_len,
    output logic        done,
    output logic [1:0]  err_code,
    output logic [23:0] rsp_data,
    output logic [1:0]  rsp_cnt,
    output logic        scan_valid,
    output logic [7:0]  scan_data,
    output logic        tx_en,
    output logic [7:0]  tx_data,
    input  logic        tx_ack,
    input  logic        tx_err,
    input  logic        tx_busy,
    output logic        rx_en,
    input  logic        rx_ack,
    input  logic        rx_err,
    input  logic [7:0]  rx_data
);

    typedef enum logic [2:0] {
        IDLE, SEND_CMD, ACK_CMD, SEND_ARG, ACK_ARG, RECV, DONE
    } state_t;

    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]  RETRY_LIMIT  = 8'(MAX_RETRY);
    localparam logic [7:0]  BYTE_ACK     = 8'hFA;
    localparam logic [7:0]  BYTE_RESEND  = 8'hFE;
    localparam logic [1:0]  ERR_OK       = 2'd0;
    localparam logic [1:0]  ERR_TIMEOUT  = 2'd1;
    localparam logic [1:0]  ERR_RETRY    = 2'd2;
    localparam logic [1:0]  ERR_BAD      = 2'd3;

    // CLK_FREQ only matters to the ps2_host instance beside this block.
    if (CLK_FREQ <= 0) begin : g_clk_freq_unset
    end

    state_t      state;
    logic [7:0]  arg_q;
    logic        has_arg_q;
    logic [1:0]  len_q;
    logic [7:0]  retry_cnt;
    logic [31:0] tmo_cnt;
    logic        timed_out;

    assign timed_out = (tmo_cnt == TIMEOUT_LAST);

    // Transaction FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cmd_ready  <= 1'b1;
            done       <= 1'b0;
            err_code   <= ERR_OK;
            rsp_data   <= '0;
            rsp_cnt    <= '0;
            scan_valid <= 1'b0;
            scan_data  <= '0;
            tx_en      <= 1'b0;
            tx_data    <= '0;
            rx_en      <= 1'b0;
            arg_q      <= '0;
            has_arg_q  <= 1'b0;
            len_q      <= '0;
            retry_cnt  <= '0;
            tmo_cnt    <= '0;
        end else begin
            done       <= 1'b0;
            scan_valid <= 1'b0;
            case (state)
                IDLE: begin
                    rx_en     <= 1'b1;
                    cmd_ready <= 1'b1;
                    if (rx_ack && !rx_err) begin
                        scan_valid <= 1'b1;
                        scan_data  <= rx_data;
                    end
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        rx_en     <= 1'b0;
                        tx_en     <= 1'b1;
                        tx_data   <= cmd_byte;
                        arg_q     <= cmd_arg;
                        has_arg_q <= cmd_has_arg;
                        len_q     <= cmd_rsp_len;
                        rsp_data  <= '0;
                        rsp_cnt   <= '0;
                        retry_cnt <= '0;
                        tmo_cnt   <= '0;
                        state     <= SEND_CMD;
                    end
                end
                SEND_CMD, SEND_ARG: begin
                    if (tx_ack) begin
                        // tx_ack beats a timeout expiring in the same cycle
                        tx_en   <= 1'b0;
                        rx_en   <= 1'b1;
                        tmo_cnt <= '0;
                        state   <= (state == SEND_CMD) ? ACK_CMD : ACK_ARG;
                    end else if (tx_err) begin
                        tx_en   <= 1'b0;
                        tmo_cnt <= '0;
                        if (retry_cnt == RETRY_LIMIT) begin
                            err_code <= ERR_RETRY;
                            state    <= DONE;
                        end else begin
                            retry_cnt <= retry_cnt + 8'd1;
                        end
                    end else if (timed_out) begin
                        tx_en    <= 1'b0;
                        err_code <= ERR_TIMEOUT;
                        state    <= DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 32'd1;
                        // after a tx_err, wait for the host to settle before resending
                        if (!tx_en && !tx_busy) tx_en <= 1'b1;
                    end
                end
                ACK_CMD, ACK_ARG: begin
                    if (rx_err) begin
                        err_code <= ERR_BAD;
                        state    <= DONE;
                    end else if (rx_ack) begin
                        tmo_cnt <= '0;
                        if (rx_data == BYTE_ACK) begin
                            if (state == ACK_CMD && has_arg_q) begin
                                tx_en   <= 1'b1;
                                tx_data <= arg_q;
                                rx_en   <= 1'b0;
                                state   <= SEND_ARG;
                            end else if (len_q != 2'd0) begin
                                state <= RECV;
                            end else begin
                                err_code <= ERR_OK;
                                state    <= DONE;
                            end
                        end else if (rx_data == BYTE_RESEND) begin
                            if (retry_cnt == RETRY_LIMIT) begin
                                err_code <= ERR_RETRY;
                                state    <= DONE;
                            end else begin
                                // tx_data still holds the byte being acknowledged
                                retry_cnt <= retry_cnt + 8'd1;
                                tx_en     <= 1'b1;
                                rx_en     <= 1'b0;
                                state     <= (state == ACK_CMD) ? SEND_CMD : SEND_ARG;
                            end
                        end else begin
                            err_code <= ERR_BAD;
                            state    <= DONE;
                        end
                    end else if (timed_out) begin
                        err_code <= ERR_TIMEOUT;
                        state    <= DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 32'd1;
                    end
                end
                RECV: begin
                    if (rx_err) begin
                        err_code <= ERR_BAD;
                        state    <= DONE;
                    end else if (rx_ack) begin
                        case (rsp_cnt)
                            2'd0:    rsp_data[7:0]   <= rx_data;
                            2'd1:    rsp_data[15:8]  <= rx_data;
                            default: rsp_data[23:16] <= rx_data;
                        endcase
                        rsp_cnt <= rsp_cnt + 2'd1;
                        tmo_cnt <= '0;
                        if (rsp_cnt + 2'd1 == len_q) begin
                            err_code <= ERR_OK;
                            state    <= DONE;
                        end
                    end else if (timed_out) begin
                        err_code <= ERR_TIMEOUT;
                        state    <= DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 32'd1;
                    end
                end
                default: begin
                    // DONE: single done pulse; cmd_ready follows one cycle later
                    done  <= 1'b1;
                    rx_en <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_cmd_seq.sv
`timescale 1ns/1ps
// Testbench for ps2_cmd_seq: emulates ps2_host plus a PS/2 device replying
// from a scripted list, and compares each transaction against a
// transaction-level reference model.
module tb_ps2_cmd_seq;

    localparam int TMO  = 1000;
    localparam int MAXR = 3;
    localparam int SIL  = 256;   // device stays silent from here on
    localparam int RXE  = 257;   // device reply arrives as rx_err

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [7:0]  cmd_byte = '0;
    logic        cmd_has_arg = 1'b0;
    logic [7:0]  cmd_arg = '0;
    logic [1:0]  cmd_rsp_len = '0;
    logic        done;
    logic [1:0]  err_code;
    logic [23:0] rsp_data;
    logic [1:0]  rsp_cnt;
    logic        scan_valid;
    logic [7:0]  scan_data;
    logic        tx_en;
    logic [7:0]  tx_data;
    logic        tx_ack = 1'b0;
    logic        tx_err = 1'b0;
    logic        tx_busy = 1'b0;
    logic        rx_en;
    logic        rx_ack = 1'b0;
    logic        rx_err = 1'b0;
    logic [7:0]  rx_data = '0;

    always #5 clk = ~clk;

    ps2_cmd_seq #(.CLK_FREQ(100), .TIMEOUT_CYCLES(TMO), .MAX_RETRY(MAXR)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_byte(cmd_byte), .cmd_has_arg(cmd_has_arg), .cmd_arg(cmd_arg),
        .cmd_rsp_len(cmd_rsp_len), .done(done), .err_code(err_code),
        .rsp_data(rsp_data), .rsp_cnt(rsp_cnt), .scan_valid(scan_valid),
        .scan_data(scan_data), .tx_en(tx_en), .tx_data(tx_data),
        .tx_ack(tx_ack), .tx_err(tx_err), .tx_busy(tx_busy), .rx_en(rx_en),
        .rx_ack(rx_ack), .rx_err(rx_err), .rx_data(rx_data)
    );

    int n_checks = 0;
    int n_errors = 0;

    int          reps[$];
    int          n_txerr = 0;
    logic [7:0]  exp_tx[$];
    logic [1:0]  exp_err;
    logic [23:0] exp_rsp;
    logic [1:0]  exp_cnt;
    logic        exp_silent;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Transaction-level model: walk the device script byte by byte.
    task automatic model_txn(input logic [7:0] c, input logic ha, input logic [7:0] a,
                             input logic [1:0] len);
        logic [7:0] b[2];
        int nb, idx, r, retries, txe, err, rep, cnt;
        b[0] = c; b[1] = a;
        nb = ha ? 2 : 1;
        idx = 0; r = 0; retries = 0; txe = n_txerr; err = -1; cnt = 0;
        exp_tx.delete();
        exp_rsp = '0;
        while (err < 0 && idx < nb) begin
            exp_tx.push_back(b[idx]);
            if (txe > 0) begin
                txe--; retries++;
                if (retries > MAXR) err = 2;
            end else begin
                rep = reps[r]; r++;
                if (rep == SIL) err = 1;
                else if (rep == RXE) err = 3;
                else if (rep == 'hFA) idx++;
                else if (rep == 'hFE) begin
                    retries++;
                    if (retries > MAXR) err = 2;
                end else err = 3;
            end
        end
        while (err < 0 && cnt < int'(len)) begin
            rep = reps[r]; r++;
            if (rep == SIL) err = 1;
            else if (rep == RXE) err = 3;
            else begin
                exp_rsp = exp_rsp | (24'(rep) << (8 * cnt));
                cnt++;
            end
        end
        if (err < 0) err = 0;
        exp_err    = 2'(err);
        exp_cnt    = 2'(cnt);
        exp_silent = (err == 1);
    endtask

    // Issue one request, play host and device, then compare with the model.
    task automatic run_txn(input string tag, input logic [7:0] c, input logic ha,
                           input logic [7:0] a, input logic [1:0] len,
                           input logic with_scan, input logic [7:0] scan_b);
        logic [7:0] got_tx[$];
        logic [1:0] got_err;
        logic       rdy_at_done;
        int cyc, mode, dly, last_evt, done_at, txe, scans, ri, rep, wait_cyc;
        bit seen_done;
        model_txn(c, ha, a, len);
        wait_cyc = 0;
        while (!cmd_ready && wait_cyc < 50) begin
            @(negedge clk); wait_cyc++;
        end
        check({tag, "_ready"}, 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1; cmd_byte = c; cmd_has_arg = ha; cmd_arg = a; cmd_rsp_len = len;
        if (with_scan) begin rx_ack = 1'b1; rx_data = scan_b; end
        @(negedge clk);
        cmd_valid = 1'b0; rx_ack = 1'b0;
        check({tag, "_txen_rise"}, 32'(tx_en), 32'd1);
        if (with_scan) begin
            check({tag, "_scan_v"}, 32'(scan_valid), 32'd1);
            check({tag, "_scan_d"}, 32'(scan_data), 32'(scan_b));
        end
        mode = 0; dly = 0; cyc = 0; last_evt = 0; done_at = 0; seen_done = 0;
        scans = 0; txe = n_txerr; ri = 0; got_err = '0; rdy_at_done = 1'b0;
        while (!seen_done && cyc < 3 * TMO) begin
            if (done) begin
                seen_done = 1; done_at = cyc; got_err = err_code; rdy_at_done = cmd_ready;
            end else begin
                if (cyc > 0 && scan_valid) scans++;
                if ((mode == 0 || mode == 2) && tx_en) begin
                    got_tx.push_back(tx_data);
                    dly = $urandom_range(1, 4);
                    mode = 1;
                end else if (mode == 1) begin
                    if (dly > 1) dly--;
                    else begin
                        if (txe > 0) begin txe--; tx_err = 1'b1; mode = 0; end
                        else begin tx_ack = 1'b1; mode = 2; dly = $urandom_range(2, 5); end
                        last_evt = cyc + 1;
                    end
                end else if (mode == 2) begin
                    if (dly > 1) dly--;
                    else if (ri >= reps.size()) mode = 3;
                    else begin
                        rep = reps[ri]; ri++;
                        if (rep == SIL) mode = 3;
                        else begin
                            if (rep == RXE) rx_err = 1'b1;
                            else begin rx_ack = 1'b1; rx_data = 8'(rep); end
                            last_evt = cyc + 1;
                            dly = $urandom_range(2, 5);
                        end
                    end
                end
                @(negedge clk); cyc++;
                tx_ack = 1'b0; tx_err = 1'b0; rx_ack = 1'b0; rx_err = 1'b0;
            end
        end
        check({tag, "_done_seen"}, 32'(seen_done), 32'd1);
        check({tag, "_ntx"}, 32'(got_tx.size()), 32'(exp_tx.size()));
        for (int i = 0; i < got_tx.size() && i < exp_tx.size(); i++)
            check({tag, "_txbyte"}, 32'(got_tx[i]), 32'(exp_tx[i]));
        check({tag, "_err"}, 32'(got_err), 32'(exp_err));
        check({tag, "_rsp"}, 32'(rsp_data), 32'(exp_rsp));
        check({tag, "_rspcnt"}, 32'(rsp_cnt), 32'(exp_cnt));
        check({tag, "_latency"}, 32'(done_at - last_evt), exp_silent ? 32'(TMO + 1) : 32'd1);
        check({tag, "_noscan"}, 32'(scans), 32'd0);
        check({tag, "_rdy_low"}, 32'(rdy_at_done), 32'd0);
        @(negedge clk);
        check({tag, "_done_1cyc"}, 32'(done), 32'd0);
        check({tag, "_rdy_back"}, 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        int p, dcount;

        // reset state
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(cmd_ready), 32'd1);
        check("rst_outs", {done, err_code, rsp_cnt, scan_valid, tx_en, rx_en},
              32'd0);
        check("rst_data", {rsp_data, 8'h00}, 32'd0);
        check("rst_bytes", {16'h0, scan_data, tx_data}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // reset in the middle of SEND_CMD
        cmd_valid = 1'b1; cmd_byte = 8'hF4; cmd_has_arg = 1'b0; cmd_rsp_len = 2'd0;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("midrst_txen_hi", 32'(tx_en), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_txen_lo", 32'(tx_en), 32'd0);
        check("midrst_ready", 32'(cmd_ready), 32'd1);
        rst = 1'b0;
        dcount = 0;
        for (int i = 0; i < 6; i++) begin
            if (done) dcount++;
            @(negedge clk);
        end
        check("midrst_nodone", 32'(dcount), 32'd0);

        // pass-through in IDLE, and rx_err in IDLE is dropped
        rx_ack = 1'b1; rx_data = 8'h1C;
        @(negedge clk);
        rx_ack = 1'b0;
        check("scan_valid", 32'(scan_valid), 32'd1);
        check("scan_data", 32'(scan_data), 32'h1C);
        @(negedge clk);
        check("scan_pulse_1cyc", 32'(scan_valid), 32'd0);
        rx_err = 1'b1; rx_data = 8'h55;
        @(negedge clk);
        rx_err = 1'b0;
        check("scan_rxerr_idle", 32'(scan_valid), 32'd0);

        // directed transactions
        n_txerr = 0;
        reps = '{'hFA, 'hFA, SIL};            run_txn("arg_ed07", 8'hED, 1'b1, 8'h07, 2'd0, 1'b0, 8'h00);
        reps = '{'hFA, 'hAB, 'h83, SIL};      run_txn("rsp_f2", 8'hF2, 1'b0, 8'h00, 2'd2, 1'b0, 8'h00);
        check("rsp_f2_const", 32'(rsp_data), 32'h0000_83AB);
        reps = '{'hFE, 'hFE, 'hFA, SIL};      run_txn("resend3", 8'hED, 1'b0, 8'h00, 2'd0, 1'b0, 8'h00);
        reps = '{'hFE, 'hFE, 'hFE, 'hFE, SIL}; run_txn("resend_x", 8'hED, 1'b0, 8'h00, 2'd0, 1'b0, 8'h00);
        check("resend_x_err", 32'(err_code), 32'd2);
        reps = '{SIL};                         run_txn("tmo_ack", 8'hED, 1'b0, 8'h00, 2'd0, 1'b0, 8'h00);
        reps = '{'hFC, SIL};                   run_txn("bad_fc", 8'hED, 1'b0, 8'h00, 2'd0, 1'b0, 8'h00);
        reps = '{'hFA, 'h1C, SIL};             run_txn("recv_1c", 8'hF2, 1'b0, 8'h00, 2'd1, 1'b0, 8'h00);
        reps = '{'hFA, 'hAA, SIL};             run_txn("tmo_recv", 8'hF2, 1'b0, 8'h00, 2'd3, 1'b0, 8'h00);
        reps = '{'hFA, 'hFE, 'hFA, SIL};       run_txn("arg_resend", 8'hF3, 1'b1, 8'h20, 2'd0, 1'b0, 8'h00);
        reps = '{'hFA, RXE, SIL};              run_txn("rxerr_recv", 8'hF2, 1'b0, 8'h00, 2'd1, 1'b0, 8'h00);
        reps = '{'hFA, 'h12, 'h34, 'h56, SIL}; run_txn("scan_accept", 8'hF2, 1'b0, 8'h00, 2'd3, 1'b1, 8'h5A);
        n_txerr = 2;
        reps = '{'hFA, SIL};                   run_txn("txerr2", 8'hFF, 1'b0, 8'h00, 2'd0, 1'b0, 8'h00);
        n_txerr = 4;
        reps = '{'hFA, SIL};                   run_txn("txerr_x", 8'hFF, 1'b0, 8'h00, 2'd0, 1'b0, 8'h00);

        // randomized transactions
        for (int t = 0; t < 30; t++) begin
            reps.delete();
            for (int i = 0; i < 8; i++) begin
                p = $urandom_range(0, 99);
                if (p < 55)      reps.push_back('hFA);
                else if (p < 70) reps.push_back('hFE);
                else if (p < 94) reps.push_back(int'($urandom_range(0, 255)));
                else if (p < 97) reps.push_back(RXE);
                else             reps.push_back(SIL);
            end
            reps.push_back(SIL);
            n_txerr = ($urandom_range(0, 9) == 0) ? 1 : 0;
            run_txn("rnd", 8'($urandom), 1'($urandom), 8'($urandom), 2'($urandom),
                    1'($urandom_range(0, 3) == 0), 8'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
